// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the stage sequencer and its environment.
// With STAGE_SEQ_PERF_EN defined the bundle also carries stall_cycles.
interface stage_sequencer_if;
   logic        run;
   logic        fetch_ready;
   logic        mem_ready;
   logic [5:0]  opcode_in;
   logic [5:0]  func_in;
   logic        enable_fetch;
   logic        enable_decode;
   logic        enable_execute;
   logic        enable_memory;
   logic        enable_writeback;
   logic        pc_write;
   logic        busy;
   logic [31:0] insn_retired;
`ifdef STAGE_SEQ_PERF_EN
   logic [31:0] stall_cycles;
`endif

   modport master (
      output run, fetch_ready, mem_ready, opcode_in, func_in,
      input  enable_fetch, enable_decode, enable_execute, enable_memory, enable_writeback,
      input  pc_write, busy, insn_retired
`ifdef STAGE_SEQ_PERF_EN
      , input stall_cycles
`endif
   );

   modport slave (
      input  run, fetch_ready, mem_ready, opcode_in, func_in,
      output enable_fetch, enable_decode, enable_execute, enable_memory, enable_writeback,
      output pc_write, busy, insn_retired
`ifdef STAGE_SEQ_PERF_EN
      , output stall_cycles
`endif
   );
endinterface

// File: rtl/stage_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback sequencer, one instruction at a time.
// Define STAGE_SEQ_PERF_EN to add the stall_cycles performance counter.
module stage_sequencer #(
   parameter int unsigned MULDIV_CYCLES = 4,
   parameter int unsigned ALU_CYCLES    = 1
) (
   input logic              clock,
   input logic              reset_n,
   stage_sequencer_if.slave bus
);

   typedef enum logic [2:0] {
      StIdle, StFetch, StDecode, StExecute, StMemory, StWriteback
   } state_e;

   typedef enum logic [1:0] {ClsNowrite, ClsLoad, ClsStore, ClsWrite} cls_e;

   localparam logic [3:0] MulLast = 4'(MULDIV_CYCLES - 1);
   localparam logic [3:0] AluLast = 4'(ALU_CYCLES - 1);

   state_e      state_q;
   cls_e        cls_q;
   logic [3:0]  cnt_q;
   logic        exec_first_q;
   logic [31:0] retired_q;

   cls_e        cur_cls;
   logic [3:0]  cur_cnt;
   logic        retire;

   function automatic logic is_muldiv(logic [5:0] op, logic [5:0] fn);
      return (op == 6'b000000) && (fn[5:2] == 4'b0110);
   endfunction

   function automatic cls_e classify(logic [5:0] op, logic [5:0] fn);
      cls_e c;
      unique case (op)
         6'b100011, 6'b100000, 6'b100100: c = ClsLoad;
         6'b101011, 6'b101000:            c = ClsStore;
         6'b000100, 6'b000101, 6'b000111, 6'b000010: c = ClsNowrite;
         6'b000011:                       c = ClsWrite;
         6'b000000: c = ((fn == 6'b001000) || is_muldiv(op, fn)) ? ClsNowrite : ClsWrite;
         // Immediate ALU group (ADDI..LUI) writes a register; anything else is unknown
         default:   c = (op[5:3] == 3'b001) ? ClsWrite : ClsNowrite;
      endcase
      return c;
   endfunction

   function automatic state_e end_state(logic run);
      return run ? StFetch : StIdle;
   endfunction

   // opcode/func are only valid in the first EXECUTE cycle; later cycles use the latched copy
   always_comb begin
      cur_cls = exec_first_q ? classify(bus.opcode_in, bus.func_in) : cls_q;
      cur_cnt = exec_first_q ? (is_muldiv(bus.opcode_in, bus.func_in) ? MulLast : AluLast)
                             : cnt_q;
      retire  = 1'b0;
      unique case (state_q)
         StExecute:   retire = (cur_cnt == 4'd0) && (cur_cls == ClsNowrite);
         StMemory:    retire = bus.mem_ready && (cls_q == ClsStore);
         StWriteback: retire = 1'b1;
         default:     retire = 1'b0;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         cls_q        <= ClsNowrite;
         cnt_q        <= 4'd0;
         exec_first_q <= 1'b0;
         retired_q    <= 32'd0;
      end else begin
         exec_first_q <= 1'b0;
         if (retire) retired_q <= retired_q + 32'd1;
         unique case (state_q)
            StIdle:  if (bus.run) state_q <= StFetch;
            StFetch: if (bus.fetch_ready) state_q <= StDecode;
            StDecode: begin
               state_q      <= StExecute;
               exec_first_q <= 1'b1;
            end
            StExecute: begin
               if (exec_first_q) cls_q <= cur_cls;
               if (cur_cnt != 4'd0) begin
                  cnt_q <= cur_cnt - 4'd1;
               end else begin
                  cnt_q <= 4'd0;
                  unique case (cur_cls)
                     ClsLoad, ClsStore: state_q <= StMemory;
                     ClsWrite:          state_q <= StWriteback;
                     default:           state_q <= end_state(bus.run);
                  endcase
               end
            end
            StMemory: begin
               if (bus.mem_ready) begin
                  state_q <= (cls_q == ClsLoad) ? StWriteback : end_state(bus.run);
               end
            end
            StWriteback: state_q <= end_state(bus.run);
            default:     state_q <= StIdle;
         endcase
      end
   end

   assign bus.enable_fetch     = (state_q == StFetch);
   assign bus.enable_decode    = (state_q == StDecode);
   assign bus.enable_execute   = (state_q == StExecute);
   assign bus.enable_memory    = (state_q == StMemory);
   assign bus.enable_writeback = (state_q == StWriteback);
   assign bus.busy             = (state_q != StIdle);
   assign bus.pc_write         = retire;
   assign bus.insn_retired     = retired_q;

`ifdef STAGE_SEQ_PERF_EN
   logic [31:0] stall_q;
   logic        stall_now;

   assign stall_now = ((state_q == StFetch)   && !bus.fetch_ready) ||
                      ((state_q == StMemory)  && !bus.mem_ready)   ||
                      ((state_q == StExecute) && (cur_cnt != 4'd0));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         stall_q <= 32'd0;
      end else if (stall_now) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign bus.stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_stage_sequencer.sv
// Self-checking bench for stage_sequencer: directed scenarios plus randomized traffic
// against an instruction-level model; also checks stall_cycles when STAGE_SEQ_PERF_EN is set.
module tb_stage_sequencer;
   localparam int MulC = 4;
   localparam int AluC = 1;
   localparam int PIdle = 0, PFetch = 1, PDec = 2, PExec = 3, PMem = 4, PWb = 5;

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   stage_sequencer_if bus ();

   stage_sequencer #(.MULDIV_CYCLES(MulC), .ALU_CYCLES(AluC)) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int errors = 0;

   // Model state: phase, execute cycles done/length, class (0 nowrite,1 load,2 store,3 write)
   int ph, done, len, cls;
   logic [31:0] m_ret, m_stall;
   // DUT outputs seen in the most recent step
   logic s_f, s_d, s_x, s_m, s_w, s_pcw, s_busy;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit is_muldiv(logic [5:0] op, logic [5:0] fn);
      return op == 6'd0 && fn >= 6'b011000 && fn <= 6'b011011;
   endfunction

   function automatic int classify(logic [5:0] op, logic [5:0] fn);
      logic [5:0] loads [3] = '{6'b100011, 6'b100000, 6'b100100};
      logic [5:0] stores[2] = '{6'b101011, 6'b101000};
      logic [5:0] nw    [4] = '{6'b000100, 6'b000101, 6'b000111, 6'b000010};
      foreach (loads[i]) if (op == loads[i]) return 1;
      foreach (stores[i]) if (op == stores[i]) return 2;
      foreach (nw[i]) if (op == nw[i]) return 0;
      if (op == 6'd0) return (fn == 6'b001000 || is_muldiv(op, fn)) ? 0 : 3;
      if (op == 6'b000011 || (op >= 6'b001000 && op <= 6'b001111)) return 3;
      return 0;
   endfunction

   task automatic model_reset();
      ph = PIdle; done = 0; len = 1; cls = 0; m_ret = 0; m_stall = 0;
   endtask

   task automatic check_all_zero(input string tag);
      logic [7:0] v;
      v = {bus.enable_fetch, bus.enable_decode, bus.enable_execute, bus.enable_memory,
           bus.enable_writeback, bus.pc_write, bus.busy, 1'b0};
      check({tag, "_strobes"}, {24'd0, v}, 32'd0);
      check({tag, "_retired"}, bus.insn_retired, 32'd0);
`ifdef STAGE_SEQ_PERF_EN
      check({tag, "_stall"}, bus.stall_cycles, 32'd0);
`endif
   endtask

   // Called at a falling edge: drive one cycle, compare, advance model, wait next falling edge
   task automatic step(input logic r, input logic fr, input logic mr,
                       input logic [5:0] op, input logic [5:0] fn);
      logic pcw;
      bus.run = r; bus.fetch_ready = fr; bus.mem_ready = mr;
      bus.opcode_in = op; bus.func_in = fn;
      #1;
      if (ph == PExec && done == 0) begin
         len = is_muldiv(op, fn) ? MulC : AluC;
         cls = classify(op, fn);
      end
      pcw = (ph == PExec && done + 1 == len && cls == 0) ||
            (ph == PMem && mr && cls == 2) || (ph == PWb);
      check("enable_fetch", bus.enable_fetch, ph == PFetch);
      check("enable_decode", bus.enable_decode, ph == PDec);
      check("enable_execute", bus.enable_execute, ph == PExec);
      check("enable_memory", bus.enable_memory, ph == PMem);
      check("enable_writeback", bus.enable_writeback, ph == PWb);
      check("busy", bus.busy, ph != PIdle);
      check("pc_write", bus.pc_write, pcw);
      check("insn_retired", bus.insn_retired, m_ret);
`ifdef STAGE_SEQ_PERF_EN
      check("stall_cycles", bus.stall_cycles, m_stall);
`endif
      s_f = bus.enable_fetch; s_d = bus.enable_decode; s_x = bus.enable_execute;
      s_m = bus.enable_memory; s_w = bus.enable_writeback; s_pcw = bus.pc_write;
      s_busy = bus.busy;
      if ((ph == PFetch && !fr) || (ph == PMem && !mr) || (ph == PExec && done + 1 < len))
         m_stall++;
      if (pcw) m_ret++;
      case (ph)
         PIdle:  if (r) ph = PFetch;
         PFetch: if (fr) ph = PDec;
         PDec:   begin ph = PExec; done = 0; end
         PExec: begin
            done++;
            if (done == len) begin
               if (cls == 1 || cls == 2) ph = PMem;
               else if (cls == 3) ph = PWb;
               else ph = r ? PFetch : PIdle;
            end
         end
         PMem:   if (mr) ph = (cls == 1) ? PWb : (r ? PFetch : PIdle);
         default: ph = r ? PFetch : PIdle;
      endcase
      @(negedge clock);
   endtask

   // One instruction from IDLE with run dropped after issue; counts DUT strobe cycles
   task automatic run_insn(input logic [5:0] op, input logic [5:0] fn, input int fs,
                           input int ms, output int nf, output int nd, output int nx,
                           output int nm, output int nw, output int cyc);
      int fc, mc;
      logic fr, mr;
      fc = 0; mc = 0; nf = 0; nd = 0; nx = 0; nm = 0; nw = 0; cyc = 0;
      step(1'b1, 1'b1, 1'b1, op, fn);
      for (int i = 0; i < 64; i++) begin
         fr = !(ph == PFetch && fc < fs);
         mr = !(ph == PMem && mc < ms);
         if (ph == PFetch) fc++;
         if (ph == PMem) mc++;
         step(1'b0, fr, mr, op, fn);
         cyc++;
         nf += int'(s_f); nd += int'(s_d); nx += int'(s_x); nm += int'(s_m); nw += int'(s_w);
         if (s_pcw) break;
      end
   endtask

   int nf, nd, nx, nm, nw, cyc;
   logic [31:0] ret0;
`ifdef STAGE_SEQ_PERF_EN
   logic [31:0] st0;
`endif
   logic [5:0] ops [12] = '{6'd0, 6'd0, 6'd0, 6'b100011, 6'b101011, 6'b100100, 6'b000100,
                            6'b000011, 6'b001001, 6'b000010, 6'b101000, 6'b111111};
   logic [5:0] fns [6]  = '{6'b100001, 6'b011000, 6'b011011, 6'b001000, 6'b001001, 6'b100100};
   logic [5:0] cur_op, cur_fn;
   logic [5:0] drv_op, drv_fn;

   initial begin
      bus.run = 1'b0; bus.fetch_ready = 1'b0; bus.mem_ready = 1'b0;
      bus.opcode_in = '0; bus.func_in = '0;
      model_reset();
      @(negedge clock);
      #1 check_all_zero("por");
      @(negedge clock);
      reset_n = 1'b1;

      // Write path: ADDU, fetch_ready high on entry
      run_insn(6'd0, 6'b100001, 0, 0, nf, nd, nx, nm, nw, cyc);
      check("addu_cycles", cyc, 4);
      check("addu_wb", nw, 1);
      check("addu_retired", bus.insn_retired, 1);

      // Multi-cycle execute: MULT
      run_insn(6'd0, 6'b011000, 0, 0, nf, nd, nx, nm, nw, cyc);
      check("mult_exec", nx, 4);
      check("mult_wb", nw, 0);
      check("mult_cycles", cyc, 6);

      // Load/store with 3 memory stall cycles
      run_insn(6'b100011, 6'd0, 0, 3, nf, nd, nx, nm, nw, cyc);
      check("lw_mem", nm, 4);
      check("lw_wb", nw, 1);
      check("lw_cycles", cyc, 8);
      run_insn(6'b101011, 6'd0, 0, 3, nf, nd, nx, nm, nw, cyc);
      check("sw_mem", nm, 4);
      check("sw_wb", nw, 0);
      check("sw_cycles", cyc, 7);

      // Branch with 2-cycle fetch stall, run already low: idle afterwards
      run_insn(6'b000100, 6'd0, 2, 0, nf, nd, nx, nm, nw, cyc);
      check("beq_fetch", nf, 3);
      check("beq_cycles", cyc, 5);
      step(1'b0, 1'b1, 1'b1, 6'd0, 6'd0);
      check("beq_idle_busy", s_busy, 0);
      check("retired_after_five", bus.insn_retired, 5);

`ifdef STAGE_SEQ_PERF_EN
      st0 = bus.stall_cycles;
      run_insn(6'b100011, 6'd0, 2, 3, nf, nd, nx, nm, nw, cyc);
      check("perf_lw_stalls", bus.stall_cycles - st0, 5);
`endif

      // Async reset in the middle of a DIV execute
      step(1'b1, 1'b1, 1'b1, 6'd0, 6'b011010);
      for (int i = 0; i < 8 && !(ph == PExec && done == 1); i++)
         step(1'b1, 1'b1, 1'b1, 6'd0, 6'b011010);
      check("div_reached_exec", bus.enable_execute, 1);
      #2 reset_n = 1'b0;
      #1 check_all_zero("mid_reset");
      model_reset();
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 6'd0, 6'b011010);
      check("post_reset_busy", s_busy, 0);
      check("post_reset_retired", bus.insn_retired, 0);

      // Randomized traffic; opcode/func are garbage except in the first EXECUTE cycle
      cur_op = 6'd0; cur_fn = 6'b100001;
      for (int i = 0; i < 3000; i++) begin
         if (ph == PDec) begin
            if ($urandom_range(0, 3) == 0) begin
               cur_op = 6'($urandom); cur_fn = 6'($urandom);
            end else begin
               cur_op = ops[$urandom_range(0, 11)]; cur_fn = fns[$urandom_range(0, 5)];
            end
         end
         if (ph == PExec && done == 0) begin
            drv_op = cur_op; drv_fn = cur_fn;
         end else begin
            drv_op = 6'($urandom); drv_fn = 6'($urandom);
         end
         step($urandom_range(0, 7) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 2) != 0,
              drv_op, drv_fn);
      end

      // Drain to idle, then retire counter wrap
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 6'd0, 6'b100001);
      check("drained_idle", s_busy, 0);
      force dut.retired_q = 32'hFFFF_FFFF;
      #1 release dut.retired_q;
      m_ret = 32'hFFFF_FFFF;
      @(negedge clock);
      ret0 = bus.insn_retired;
      check("preload_retired", ret0, 32'hFFFF_FFFF);
      run_insn(6'd0, 6'b100001, 0, 0, nf, nd, nx, nm, nw, cyc);
      check("retired_wrap", bus.insn_retired, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
